hazard_forward_controller: RTL
==============================

Name: hazard_forward_controller

Overview:
- Backward-direction control block for the 5-stage MIPS pipeline. It reads destination-register and enable fields from the ID/EX, EX/MEM and MEM/WB pipeline registers.
- It drives three things back upstream:
  - operand forwarding selects for the ID-stage MX1/MX2 muxes;
  - load enables for the PC and IF/ID registers;
  - NOP insertion into ID/EX.
- It freezes the whole pipeline while data memory is not ready. A wait-timeout FSM and a saturating stall counter provide debug visibility.

Parameters:
- CNT_W, 16, width of STALL_COUNT.
- MEM_TIMEOUT, 15, maximum consecutive not-ready cycles tolerated before the sticky error state.

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  synchronous, active-high reset
- ID_RS  input  5  rs field of the instruction in ID
- ID_RT  input  5  rt field of the instruction in ID
- ID_USES_RS  input  1  ID instruction reads rs
- ID_USES_RT  input  1  ID instruction reads rt
- EX_RD  input  5  destination register of the instruction in EX
- EX_RF_ENABLE  input  1  EX instruction writes the register file
- EX_LOAD_INSTR  input  1  EX instruction is a load
- MEM_RD  input  5  destination register in MEM
- MEM_RF_ENABLE  input  1  MEM instruction writes the register file
- MEM_ACCESS  input  1  data memory access in MEM this cycle
- MEM_READY  input  1  data memory has completed the access
- WB_RD  input  5  destination register in WB
- WB_RF_ENABLE  input  1  WB instruction writes the register file
- FWD_A_SEL  output  2  MX1 select: 00 regfile, 01 EX, 10 MEM, 11 WB
- FWD_B_SEL  output  2  MX2 select, same encoding
- PC_LE  output  1  PC load enable
- IF_ID_LE  output  1  IF/ID load enable
- ID_EX_NOP  output  1  zero all ID/EX control inputs
- PIPE_FREEZE  output  1  hold ID/EX, EX/MEM and MEM/WB contents
- TIMEOUT_ERR  output  1  sticky memory-timeout flag
- STALL_COUNT  output  CNT_W  cycles with PC_LE=0

Behaviour:

Reset:
- Reset, synchronous, active-high; clock Clk.
- While Reset=1:
  - PC_LE=0, IF_ID_LE=0, ID_EX_NOP=1, PIPE_FREEZE=0, FWD_A_SEL=FWD_B_SEL=00, TIMEOUT_ERR=0.
  - At the clock edge: state<=RUN, wait_cnt<=0, STALL_COUNT<=0.

Forwarding (combinational):
- Evaluated independently for A (ID_RS, ID_USES_RS) and B (ID_RT, ID_USES_RT).
- Priority EX > MEM > WB. A stage matches when its RF_ENABLE=1, its RD equals the source register, and RD != 0.
- Source register 0, or the uses flag = 0, gives 00.
- Selects are computed in every state; they are don't-care while stalled but must still follow this rule.

Load-use hazard (combinational):
- hz = EX_LOAD_INSTR & EX_RF_ENABLE & (EX_RD != 0) & ((ID_USES_RS & ID_RS == EX_RD) | (ID_USES_RT & ID_RT == EX_RD)).
- hz gives PC_LE=0, IF_ID_LE=0, ID_EX_NOP=1.
- This is a single bubble; the next cycle the load sits in MEM and forwarding uses 10.

Freeze:
- frz = (MEM_ACCESS & ~MEM_READY) | (state == ERROR).
- frz gives PIPE_FREEZE=1, PC_LE=0, IF_ID_LE=0, ID_EX_NOP=0 (hold, do not bubble).
- frz has priority over hz.
- Otherwise: PC_LE = IF_ID_LE = ~hz, ID_EX_NOP = hz, PIPE_FREEZE=0.

FSM (states RUN, MEM_WAIT, ERROR; wait_cnt is 4 bits wide enough for MEM_TIMEOUT):
- RUN:
  - MEM_ACCESS & ~MEM_READY → MEM_WAIT, wait_cnt<=1.
  - Otherwise stay.
- MEM_WAIT:
  - MEM_READY=1 or MEM_ACCESS=0 → RUN, wait_cnt<=0.
  - Else wait_cnt == MEM_TIMEOUT → ERROR.
  - Else wait_cnt<=wait_cnt+1.
- ERROR:
  - TIMEOUT_ERR=1 and full freeze. Only Reset exits.
- A ready on the same cycle as a timeout comparison wins (→ RUN).

STALL_COUNT:
- +1 at each edge where Reset=0 and PC_LE=0.
- Saturates at all ones; no wrap.

Latency:
- All enables and selects are same-cycle combinational from inputs and registered state. No output register.

Test Plan:
- Forwarding priority: EX_RD=MEM_RD=WB_RD=5, all RF_ENABLE=1, ID_RS=5, ID_USES_RS=1 → FWD_A_SEL=01. Then drop EX_RF_ENABLE → 10. Then drop MEM_RF_ENABLE → 11.
- Register zero: ID_RS=ID_RT=0, EX_RD=0, EX_RF_ENABLE=1 → both selects 00, no stall.
- Load-use: EX_LOAD_INSTR=1, EX_RD=8, ID_RT=8, ID_USES_RT=1 → for one cycle PC_LE=0, IF_ID_LE=0, ID_EX_NOP=1, STALL_COUNT 0→1. Next cycle (EX cleared, MEM_RD=8) → FWD_B_SEL=10, PC_LE=1.
- Memory wait: MEM_ACCESS=1, MEM_READY=0 for 3 cycles, then 1 → PIPE_FREEZE=1 and ID_EX_NOP=0 for 3 cycles. Freeze wins over a simultaneous load-use hazard. State returns to RUN; STALL_COUNT=3.
- Timeout: MEM_READY held 0 with MEM_TIMEOUT=15 → ERROR entered after 15 wait cycles, TIMEOUT_ERR=1. Freeze persists after MEM_ACCESS drops. Reset clears everything to the reset values.
- Saturation, with CNT_W=4: hold MEM_ACCESS=1, MEM_READY=0 → STALL_COUNT stops at 15. Reset mid-MEM_WAIT → state RUN, counter 0.

Source files
------------

// File: rtl/hazard_forward_controller.sv
// Hazard and forwarding control for the 5-stage pipeline: operand forwarding
// selects, load-use bubble, memory-wait freeze with timeout FSM and stall counter.
module hazard_forward_controller #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_RS,
    input  logic [4:0]       ID_RT,
    input  logic             ID_USES_RS,
    input  logic             ID_USES_RT,
    input  logic [4:0]       EX_RD,
    input  logic             EX_RF_ENABLE,
    input  logic             EX_LOAD_INSTR,
    input  logic [4:0]       MEM_RD,
    input  logic             MEM_RF_ENABLE,
    input  logic             MEM_ACCESS,
    input  logic             MEM_READY,
    input  logic [4:0]       WB_RD,
    input  logic             WB_RF_ENABLE,
    output logic [1:0]       FWD_A_SEL,
    output logic [1:0]       FWD_B_SEL,
    output logic             PC_LE,
    output logic             IF_ID_LE,
    output logic             ID_EX_NOP,
    output logic             PIPE_FREEZE,
    output logic             TIMEOUT_ERR,
    output logic [CNT_W-1:0] STALL_COUNT
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [WAIT_W-1:0]   wait_cnt_r;
    logic [WAIT_W-1:0]   wait_cnt_nx_s;
    logic [CNT_W-1:0]    stall_cnt_r;
    logic                mem_stall_s;
    logic                hz_s;
    logic                frz_s;
    logic                pc_le_s;

    // Youngest matching producer wins; register zero never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       uses,
        input logic [4:0] ex_rd,
        input logic       ex_en,
        input logic [4:0] mem_rd,
        input logic       mem_en,
        input logic [4:0] wb_rd,
        input logic       wb_en
    );
        logic [1:0] sel;
        if (!uses || (src == 5'd0)) begin
            sel = 2'b00;
        end else if (ex_en && (ex_rd == src)) begin
            sel = 2'b01;
        end else if (mem_en && (mem_rd == src)) begin
            sel = 2'b10;
        end else if (wb_en && (wb_rd == src)) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection terms
    always_comb begin
        mem_stall_s = MEM_ACCESS & ~MEM_READY;
        hz_s        = EX_LOAD_INSTR & EX_RF_ENABLE & (EX_RD != 5'd0) &
                      ((ID_USES_RS & (ID_RS == EX_RD)) | (ID_USES_RT & (ID_RT == EX_RD)));
        frz_s       = mem_stall_s | (state_r == ST_ERROR);
    end

    // Wait-timeout FSM next state; a ready in the same cycle as the limit check returns to RUN
    always_comb begin
        state_nx_s    = state_r;
        wait_cnt_nx_s = wait_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (mem_stall_s) begin
                    state_nx_s    = ST_MEM_WAIT;
                    wait_cnt_nx_s = WAIT_W'(1);
                end else begin
                    state_nx_s    = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (MEM_READY || !MEM_ACCESS) begin
                    state_nx_s    = ST_RUN;
                    wait_cnt_nx_s = '0;
                end else if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT)) begin
                    state_nx_s    = ST_ERROR;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            ST_ERROR: begin
                state_nx_s = ST_ERROR;
            end
            default: begin
                state_nx_s    = ST_RUN;
                wait_cnt_nx_s = '0;
            end
        endcase
    end

    // FSM state and wait counter registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
        end
    end

    // Pipeline control outputs; freeze holds in place and overrides the load-use bubble
    always_comb begin
        FWD_A_SEL   = 2'b00;
        FWD_B_SEL   = 2'b00;
        pc_le_s     = 1'b0;
        IF_ID_LE    = 1'b0;
        ID_EX_NOP   = 1'b1;
        PIPE_FREEZE = 1'b0;
        TIMEOUT_ERR = 1'b0;
        if (Reset) begin
            pc_le_s     = 1'b0;
            IF_ID_LE    = 1'b0;
            ID_EX_NOP   = 1'b1;
            PIPE_FREEZE = 1'b0;
        end else begin
            FWD_A_SEL   = fwd_sel(ID_RS, ID_USES_RS, EX_RD, EX_RF_ENABLE,
                                  MEM_RD, MEM_RF_ENABLE, WB_RD, WB_RF_ENABLE);
            FWD_B_SEL   = fwd_sel(ID_RT, ID_USES_RT, EX_RD, EX_RF_ENABLE,
                                  MEM_RD, MEM_RF_ENABLE, WB_RD, WB_RF_ENABLE);
            TIMEOUT_ERR = (state_r == ST_ERROR);
            if (frz_s) begin
                pc_le_s     = 1'b0;
                IF_ID_LE    = 1'b0;
                ID_EX_NOP   = 1'b0;
                PIPE_FREEZE = 1'b1;
            end else begin
                pc_le_s     = ~hz_s;
                IF_ID_LE    = ~hz_s;
                ID_EX_NOP   = hz_s;
                PIPE_FREEZE = 1'b0;
            end
        end
        PC_LE = pc_le_s;
    end

    // Saturating count of cycles with the PC held
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_r <= '0;
        end else if (!pc_le_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign STALL_COUNT = stall_cnt_r;

endmodule
